ff_ga_sched: RTL and testbench
==============================

Name: ff_ga_sched

Overview:
- Command scheduler in front of the fixed-function graphics accelerator (FF_GA).
- Shares one FF_GA instance between NREQ requesters using round-robin arbitration at command granularity.
- Buffers each 4-beat command so FF_GA receives gap-free data, drives the FF_GA addr/data_in protocol cycle-exactly, and captures vertex results into a result buffer drained over a valid/ready port.

Parameters:
- NREQ, 2, number of requesters (2..4).
- W, 32, word width; a beat is 4 words (0:3).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  beat valid per requester.
- req_ready  out  NREQ  beat accepted per requester.
- req_op  in  NREQ x 1  0=LOAD_MATRIX, 1=VERTEX; sampled on beat 0 only.
- req_data  in  NREQ x 4 x W  command beat.
- ga_addr  out  32  to FF_GA addr.
- ga_data_in  out  4 x W  to FF_GA data_in.
- ga_data_out  in  4 x W  from FF_GA data_out.
- ga_rdy  in  1  FF_GA idle flag.
- res_valid  out  1  result beat valid.
- res_ready  in  1  result beat accepted.
- res_data  out  4 x W  result beat.
- res_id  out  clog2(NREQ)  requester that issued the vertex.
- res_last  out  1  high on result beat 3.
- busy  out  1  scheduler not in S_IDLE, or result buffer occupied.

Behaviour:
- Reset (rst=0 at posedge):
  - state=S_IDLE, RR pointer=0, all counters 0, result buffer empty.
  - Outputs: req_ready=0, ga_addr=NOP_ADDR (3), ga_data_in=0, res_valid=0, res_last=0, res_id=0, busy=0.
- ga_addr idles at NOP_ADDR (3) in every cycle not listed below. It is never left at 0, 1 or 2.
- S_IDLE:
  - Round-robin over req_valid, starting from the pointer.
  - On a win: latch grant id and op; pointer = winner+1 mod NREQ; go to S_FILL.
- S_FILL:
  - req_ready[gnt]=1 only. Each accepted beat is written to in_buf[bcnt] and bcnt increments.
  - Deasserting req_valid stalls the fill; FF_GA is untouched.
  - After beat 3 is accepted, go to S_ISSUE.
  - Grant is locked for all 4 beats; other requesters see ready=0.
- S_ISSUE:
  - Waits for ga_rdy=1.
  - For VERTEX, also waits for the result buffer to be empty.
  - In the issuing cycle T, drive ga_addr = MATRIX_ADDR (0) or VRT_ADDR (1); go to S_STREAM, scnt=0.
- S_STREAM (cycles T+1..T+4):
  - ga_data_in = in_buf[scnt]; scnt increments.
  - VERTEX: at T+4 (scnt=3) drive ga_addr=RSLT_ADDR (2); go to S_READ.
  - LOAD_MATRIX: go to S_LDEND at T+5.
- S_LDEND (T+5):
  - ga_data_in=0, ga_addr=NOP_ADDR.
  - FF_GA commits the matrix and returns to idle at T+6. Go to S_IDLE.
- S_READ (T+5..T+8):
  - Capture ga_data_out into res_buf[rcnt], rcnt=0..3; record res_id=gnt.
  - At T+8: result buffer full; go to S_IDLE.
- Result drain:
  - res_valid=1 while the buffer is full. Beat k = res_buf[k].
  - A beat advances only on res_valid & res_ready; res_last on k=3.
  - After beat 3 handshakes, the buffer is empty on the next cycle.
  - Draining overlaps freely with a new S_FILL or a matrix load.
- Latency:
  - LOAD_MATRIX: 6 cycles from issue to ga_rdy.
  - VERTEX: first res_valid at T+9.
- Ordering: commands execute in grant order. A VERTEX granted after a LOAD_MATRIX uses the new matrix.
- ga_rdy=0 in S_ISSUE (e.g. FF_GA still resetting): hold; no timeout.
- Reset mid-operation returns to S_IDLE immediately and discards in_buf and res_buf. Integration ties FF_GA rst to ~rst so both restart together.
- A VERTEX waiting on a full result buffer blocks all later grants (head-of-line; intended).
- Arithmetic is entirely in FF_GA; the scheduler never modifies data. Counters are 2-bit (bcnt, rcnt, res beat) and 3-bit (scnt).

Decomposition:
- Package ff_ga_pkg:
  - MATRIX_ADDR=0, VRT_ADDR=1, RSLT_ADDR=2, NOP_ADDR=3.
  - op enum {OP_LOAD_MATRIX, OP_VERTEX}.
  - vec4_t = logic[0:3][31:0].
  - BEATS=4.
  - Scheduler state enum.
- One sub-module, rr_arb (NREQ-wide round-robin with pointer update on grant enable).

Test Plan:
- Reset, then a single VERTEX from req0 with beats d0..d3 = {1.0,2.0,3.0,4.0}·(k+1) in Q16.16 -> ga_addr=1 at T, ga_addr=2 at T+4; res_valid at T+9; result beats equal the transpose of the input beats (identity matrix); res_id=0; res_last on beat 3.
- LOAD_MATRIX of 2×identity (0x00020000 on the diagonal), then VERTEX -> ga_addr never 2 during the load; vertex results are 2× the identity-case values.
- req0 and req1 both valid continuously -> grants alternate 0,1,0,1; req_ready never high on both; res_id alternates.
- res_ready held low after the first vertex and a second VERTEX queued -> the second stays in S_ISSUE with ga_addr=3 until all 4 result beats drain, then issues.
- req_valid toggled 1,0,1,0 during fill -> FF_GA sees no address until the 4th beat; streamed beats are contiguous at T+1..T+4.
- rst=0 asserted at T+6 of a VERTEX -> next cycle all outputs at reset values, res_valid=0; a fresh command completes normally.

Source files
------------

// File: rtl/ff_ga_sched_pkg.sv
// rtl/ff_ga_sched_pkg.sv - shared constants and types for the FF_GA command scheduler
package ff_ga_pkg;

    localparam logic [31:0] MATRIX_ADDR = 32'd0;
    localparam logic [31:0] VRT_ADDR    = 32'd1;
    localparam logic [31:0] RSLT_ADDR   = 32'd2;
    localparam logic [31:0] NOP_ADDR    = 32'd3;

    localparam int BEATS = 4;

    typedef enum logic {
        OP_LOAD_MATRIX = 1'b0,
        OP_VERTEX      = 1'b1
    } op_e;

    typedef logic [0:3][31:0] vec4_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_STREAM,
        S_LDEND,
        S_READ
    } state_e;

endpackage

// File: rtl/ff_ga_sched_if.sv
// rtl/ff_ga_sched_if.sv - requester, FF_GA and result signals of the scheduler
interface ff_ga_sched_if #(
    parameter int NREQ = 2,
    parameter int W    = 32,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            req_op;
    logic [NREQ-1:0][0:3][W-1:0] req_data;

    logic [31:0]                ga_addr;
    logic [0:3][W-1:0]          ga_data_in;
    logic [0:3][W-1:0]          ga_data_out;
    logic                       ga_rdy;

    logic                       res_valid;
    logic                       res_ready;
    logic [0:3][W-1:0]          res_data;
    logic [IDW-1:0]             res_id;
    logic                       res_last;

    logic                       busy;

    modport master (
        input  req_valid, req_op, req_data, ga_data_out, ga_rdy, res_ready,
        output req_ready, ga_addr, ga_data_in, res_valid, res_data, res_id, res_last, busy
    );

    modport slave (
        output req_valid, req_op, req_data, ga_data_out, ga_rdy, res_ready,
        input  req_ready, ga_addr, ga_data_in, res_valid, res_data, res_id, res_last, busy
    );
endinterface

// File: rtl/ff_ga_sched_rr_arb.sv
// rtl/ff_ga_sched_rr_arb.sv - round-robin arbiter; pointer moves past the winner on enabled grant
module rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    output logic            o_hit,
    output logic [IDW-1:0]  o_gnt
);
    logic [IDW-1:0] r_ptr;
    logic [IDW:0]   w_idx;

    // One extra bit holds ptr+k before the modulo fold.
    always_comb begin
        o_hit = 1'b0;
        o_gnt = '0;
        w_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW + 1)'(k);
            if (w_idx >= (IDW + 1)'(NREQ)) begin
                w_idx = w_idx - (IDW + 1)'(NREQ);
            end
            if (!o_hit && i_req[w_idx[IDW-1:0]]) begin
                o_hit = 1'b1;
                o_gnt = w_idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_en && o_hit) begin
            r_ptr <= (o_gnt == IDW'(NREQ - 1)) ? '0 : o_gnt + IDW'(1);
        end
    end
endmodule

// File: rtl/ff_ga_sched.sv
// rtl/ff_ga_sched.sv - round-robin command scheduler sharing one FF_GA between requesters
module ff_ga_sched
    import ff_ga_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    ff_ga_sched_if.master bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e                  r_state;
    state_e                  w_next;
    logic [IDW-1:0]          r_gnt;
    op_e                     r_op;
    logic [1:0]              r_bcnt;
    logic [2:0]              r_scnt;
    logic [1:0]              r_rcnt;
    logic [1:0]              r_rbeat;
    logic                    r_res_full;
    logic [IDW-1:0]          r_res_id;
    logic [0:3][0:3][W-1:0]  r_in_buf;
    logic [0:3][0:3][W-1:0]  r_res_buf;

    logic                    w_arb_en;
    logic                    w_hit;
    logic [IDW-1:0]          w_gnt;
    logic                    w_accept;
    logic                    w_issue;
    logic                    w_res_fire;

    assign w_arb_en   = (r_state == S_IDLE);
    assign w_accept   = (r_state == S_FILL) && bus.req_valid[r_gnt];
    // A vertex may only start once its results have somewhere to land.
    assign w_issue    = (r_state == S_ISSUE) && bus.ga_rdy &&
                        ((r_op == OP_LOAD_MATRIX) || !r_res_full);
    assign w_res_fire = r_res_full && bus.res_ready;

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (bus.req_valid),
        .i_en  (w_arb_en),
        .o_hit (w_hit),
        .o_gnt (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_hit) w_next = S_FILL;
            S_FILL:   if (w_accept && (r_bcnt == 2'(BEATS - 1))) w_next = S_ISSUE;
            S_ISSUE:  if (w_issue) w_next = S_STREAM;
            S_STREAM: if (r_scnt == 3'd3) w_next = (r_op == OP_VERTEX) ? S_READ : S_LDEND;
            S_LDEND:  w_next = S_IDLE;
            S_READ:   if (r_rcnt == 2'd3) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_gnt      <= '0;
            r_op       <= OP_LOAD_MATRIX;
            r_bcnt     <= '0;
            r_scnt     <= '0;
            r_rcnt     <= '0;
            r_rbeat    <= '0;
            r_res_full <= 1'b0;
            r_res_id   <= '0;
            r_in_buf   <= '0;
            r_res_buf  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_gnt  <= w_gnt;
                        r_op   <= op_e'(bus.req_op[w_gnt]);
                        r_bcnt <= '0;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_in_buf[r_bcnt] <= bus.req_data[r_gnt];
                        r_bcnt           <= r_bcnt + 2'd1;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_scnt <= '0;
                        r_rcnt <= '0;
                    end
                end
                S_STREAM: r_scnt <= r_scnt + 3'd1;
                S_READ: begin
                    r_res_buf[r_rcnt] <= bus.ga_data_out;
                    r_rcnt            <= r_rcnt + 2'd1;
                    if (r_rcnt == 2'd3) begin
                        r_res_full <= 1'b1;
                        r_res_id   <= r_gnt;
                        r_rbeat    <= '0;
                    end
                end
                default: ;
            endcase
            // READ never overlaps a drain: issue required an empty buffer.
            if (w_res_fire) begin
                r_rbeat <= r_rbeat + 2'd1;
                if (r_rbeat == 2'd3) begin
                    r_res_full <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.ga_addr    = NOP_ADDR;
        bus.ga_data_in = '0;
        case (r_state)
            S_FILL:  bus.req_ready[r_gnt] = 1'b1;
            S_ISSUE: begin
                if (w_issue) begin
                    bus.ga_addr = (r_op == OP_VERTEX) ? VRT_ADDR : MATRIX_ADDR;
                end
            end
            S_STREAM: begin
                bus.ga_data_in = r_in_buf[r_scnt[1:0]];
                if ((r_op == OP_VERTEX) && (r_scnt == 3'd3)) begin
                    bus.ga_addr = RSLT_ADDR;
                end
            end
            default: ;
        endcase
        bus.res_valid = r_res_full;
        bus.res_data  = r_res_buf[r_rbeat];
        bus.res_id    = r_res_id;
        bus.res_last  = r_res_full && (r_rbeat == 2'd3);
        bus.busy      = (r_state != S_IDLE) || r_res_full;
    end
endmodule

// File: tb/tb_ff_ga_sched.sv
// tb/tb_ff_ga_sched.sv - directed scoreboard bench for ff_ga_sched with a behavioural FF_GA
module tb_ff_ga_sched;
    import ff_ga_pkg::*;

    typedef logic [0:3][0:3][31:0] beats_t;
    typedef struct {
        vec4_t data;
        int    id;
        bit    last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ff_ga_sched_if #(.NREQ(2), .W(32)) bus ();

    ff_ga_sched #(.NREQ(2), .W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         t_vrt = -100;
    int         n_vrt = 0;
    exp_t       q[$];
    int         gnt_log[$];
    logic [1:0] prev_rdy = '0;
    logic       prev_rv  = 1'b0;
    exp_t       m_e;

    // FF_GA model: ph counts cycles after the issue cycle T.
    int         ph   = 0;
    bit         mode = 1'b0;
    vec4_t      mat  [4];
    vec4_t      vbuf [4];
    logic [63:0] acc;

    always @(posedge clk) begin
        if (!rst) begin
            ph   <= 0;
            mode <= 1'b0;
            for (int j = 0; j < 4; j++)
                for (int i = 0; i < 4; i++)
                    mat[j][i] <= (i == j) ? 32'h0001_0000 : 32'h0;
        end else if (ph == 0) begin
            if (bus.ga_addr == MATRIX_ADDR) begin
                ph <= 1; mode <= 1'b0;
            end else if (bus.ga_addr == VRT_ADDR) begin
                ph <= 1; mode <= 1'b1;
            end
        end else begin
            if (ph >= 1 && ph <= 4) vbuf[ph-1] <= bus.ga_data_in;
            if (!mode && ph == 5) begin
                mat <= vbuf;
                ph  <= 0;
            end else if (mode && ph == 8) begin
                ph <= 0;
            end else begin
                ph <= ph + 1;
            end
        end
    end

    assign bus.ga_rdy = (ph == 0);

    always_comb begin
        bus.ga_data_out = '0;
        acc = '0;
        if (mode && ph >= 5 && ph <= 8) begin
            for (int k = 0; k < 4; k++) begin
                acc = '0;
                for (int i = 0; i < 4; i++)
                    acc = acc + 64'(mat[ph-5][i]) * 64'(vbuf[k][i]);
                bus.ga_data_out[k] = 32'(acc >> 16);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            chk("addr_range", 128'(bus.ga_addr <= NOP_ADDR), 128'(1));
            if (bus.req_ready != 2'b00) begin
                chk("rdy_onehot", 128'($onehot(bus.req_ready)), 128'(1));
                chk("fill_nop", 128'(bus.ga_addr), 128'(NOP_ADDR));
                if (prev_rdy == 2'b00) gnt_log.push_back(bus.req_ready[1] ? 1 : 0);
            end
            if (bus.ga_addr == MATRIX_ADDR || bus.ga_addr == VRT_ADDR)
                chk("issue_rdy", 128'(bus.ga_rdy), 128'(1));
            if (bus.ga_addr == VRT_ADDR) begin
                chk("issue_res_empty", 128'(bus.res_valid), 128'(0));
                t_vrt = cyc;
                n_vrt++;
            end
            if (bus.ga_addr == RSLT_ADDR) chk("rslt_at_t4", 128'(cyc), 128'(t_vrt + 4));
            if (bus.res_valid && !prev_rv) chk("res_at_t9", 128'(cyc), 128'(t_vrt + 9));
            if (bus.res_valid && bus.res_ready) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected", 128'(q.size()), 128'(1));
                end else begin
                    m_e = q.pop_front();
                    chk("res_data", 128'(bus.res_data), 128'(m_e.data));
                    chk("res_id", 128'(bus.res_id), 128'(m_e.id));
                    chk("res_last", 128'(bus.res_last), 128'(m_e.last));
                end
            end
        end
        prev_rdy = bus.req_ready;
        prev_rv  = bus.res_valid;
    end

    function automatic beats_t vbeats(input int s);
        beats_t b;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++)
                b[k][i] = 32'((i + 1) * (k + 1) * s * 65536);
        return b;
    endfunction

    function automatic beats_t mbeats(input int s);
        beats_t b = '0;
        for (int j = 0; j < 4; j++) b[j][j] = 32'(s * 65536);
        return b;
    endfunction

    // Expected results: transpose of the vertex beats, scaled by the diagonal.
    function automatic beats_t exp_res(input beats_t v, input int s);
        beats_t e;
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++)
                e[j][k] = 32'(v[k][j] * 32'(s));
        return e;
    endfunction

    task automatic push_exp(input beats_t e, input int id);
        for (int j = 0; j < 4; j++) q.push_back('{data: e[j], id: id, last: (j == 3)});
    endtask

    task automatic send(input int id, input bit op, input beats_t d, input bit gap);
        int b = 0;
        int n = 0;
        while (b < 4 && n < 300) begin
            @(negedge clk);
            bus.req_valid[id] = gap ? ((n % 2) == 0) : 1'b1;
            bus.req_op[id]    = op;
            bus.req_data[id]  = d[b];
            n++;
            #1;
            if (bus.req_valid[id] && bus.req_ready[id]) b++;
        end
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
        chk("send_done", 128'(b), 128'(4));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((q.size() != 0 || bus.busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(q.size()), 128'(0));
        chk({tag, "_idle"}, 128'(bus.busy), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_req_ready"}, 128'(bus.req_ready), 128'(0));
        chk({p, "_ga_addr"}, 128'(bus.ga_addr), 128'(NOP_ADDR));
        chk({p, "_ga_data_in"}, 128'(bus.ga_data_in), 128'(0));
        chk({p, "_res_valid"}, 128'(bus.res_valid), 128'(0));
        chk({p, "_res_last"}, 128'(bus.res_last), 128'(0));
        chk({p, "_res_id"}, 128'(bus.res_id), 128'(0));
        chk({p, "_busy"}, 128'(bus.busy), 128'(0));
    endtask

    initial begin
        int n0;
        int n;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 1'b1;

        // single vertex through the identity matrix
        push_exp(exp_res(vbeats(1), 1), 0);
        send(0, 1'b1, vbeats(1), 1'b0);
        wait_drain("t1_drain");
        chk("t1_issues", 128'(n_vrt), 128'(1));

        // load 2x identity, then the same vertex
        send(0, 1'b0, mbeats(2), 1'b0);
        push_exp(exp_res(vbeats(1), 2), 0);
        send(0, 1'b1, vbeats(1), 1'b0);
        wait_drain("t2_drain");

        // two requesters contending
        do_reset();
        gnt_log.delete();
        push_exp(exp_res(vbeats(1), 1), 0);
        push_exp(exp_res(vbeats(2), 1), 1);
        push_exp(exp_res(vbeats(3), 1), 0);
        push_exp(exp_res(vbeats(4), 1), 1);
        fork
            begin
                send(0, 1'b1, vbeats(1), 1'b0);
                send(0, 1'b1, vbeats(3), 1'b0);
            end
            begin
                send(1, 1'b1, vbeats(2), 1'b0);
                send(1, 1'b1, vbeats(4), 1'b0);
            end
        join
        wait_drain("t3_drain");
        chk("t3_grants", 128'(gnt_log.size()), 128'(4));
        for (int i = 0; i < gnt_log.size(); i++) chk("t3_gnt_order", 128'(gnt_log[i]), 128'(i % 2));

        // full result buffer blocks the next vertex
        bus.res_ready = 1'b0;
        n0 = n_vrt;
        push_exp(exp_res(vbeats(2), 1), 0);
        send(0, 1'b1, vbeats(2), 1'b0);
        push_exp(exp_res(vbeats(3), 1), 1);
        send(1, 1'b1, vbeats(3), 1'b0);
        repeat (20) @(negedge clk);
        chk("t4_one_issue", 128'(n_vrt - n0), 128'(1));
        chk("t4_res_valid", 128'(bus.res_valid), 128'(1));
        chk("t4_addr_nop", 128'(bus.ga_addr), 128'(NOP_ADDR));
        chk("t4_busy", 128'(bus.busy), 128'(1));
        bus.res_ready = 1'b1;
        wait_drain("t4_drain");
        chk("t4_two_issues", 128'(n_vrt - n0), 128'(2));

        // gappy fill
        push_exp(exp_res(vbeats(4), 1), 1);
        send(1, 1'b1, vbeats(4), 1'b1);
        wait_drain("t5_drain");

        // reset in the middle of a vertex read
        push_exp(exp_res(vbeats(1), 1), 0);
        send(0, 1'b1, vbeats(1), 1'b0);
        n = 0;
        while (bus.ga_addr !== VRT_ADDR && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_issue_seen", 128'(bus.ga_addr), 128'(VRT_ADDR));
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset("t6");
        rst = 1'b1;
        q.delete();
        push_exp(exp_res(vbeats(2), 1), 1);
        send(1, 1'b1, vbeats(2), 1'b0);
        wait_drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
